// File: rtl/aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// aes_job_scheduler : round-robin, credit-limited issue front end for a shared
//                     fully pipelined AES-128 core, with tagged response FIFO
// Revision          : 1.0
// ============================================================================
module aes_job_scheduler #(
    parameter int NREQ       = 2,
    parameter int LATENCY    = 21,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 32,
    parameter int SRC_W      = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*128-1:0]     req_state,
    input  logic [NREQ*128-1:0]     req_key,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic [127:0]            core_state,
    output logic [127:0]            core_key,
    input  logic [127:0]            core_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [127:0]            rsp_data,
    output logic [SRC_W-1:0]        rsp_src,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic                    busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int UW = CW + 2;

    // Issue stage registers
    logic [SRC_W-1:0]   rr_q, rr_d;
    logic [127:0]       core_state_q, core_state_d;
    logic [127:0]       core_key_q, core_key_d;
    logic               issue_v_q, issue_v_d;
    logic [SRC_W-1:0]   issue_src_q, issue_src_d;
    logic [TAG_W-1:0]   issue_tag_q, issue_tag_d;

    // Shadow pipeline mirroring the core
    logic               sh_v_q   [LATENCY];
    logic [SRC_W-1:0]   sh_src_q [LATENCY];
    logic [TAG_W-1:0]   sh_tag_q [LATENCY];

    logic [CW-1:0]      in_flight_q, in_flight_d;

    // Response FIFO
    logic [127:0]       fifo_data_q [FIFO_DEPTH];
    logic [SRC_W-1:0]   fifo_src_q  [FIFO_DEPTH];
    logic [TAG_W-1:0]   fifo_tag_q  [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;

    // Combinational
    logic               w_grant_any;
    logic [SRC_W-1:0]   w_grant_idx;
    logic [SRC_W:0]     w_scan_sum;
    logic [SRC_W-1:0]   w_scan_idx;
    logic [127:0]       w_sel_state;
    logic [127:0]       w_sel_key;
    logic [TAG_W-1:0]   w_sel_tag;
    logic [UW-1:0]      w_credit_used;
    logic               w_issue_ok;
    logic               w_hs;
    logic               w_push;
    logic               w_pop;

    // First valid requester at or after rr, with wrap
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_sum = {1'b0, rr_q} + (SRC_W+1)'(k);
            if (w_scan_sum >= (SRC_W+1)'(NREQ)) begin
                w_scan_sum = w_scan_sum - (SRC_W+1)'(NREQ);
            end
            w_scan_idx = w_scan_sum[SRC_W-1:0];
            if (!w_grant_any && req_valid[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_sel_state = '0;
        w_sel_key   = '0;
        w_sel_tag   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == SRC_W'(i)) begin
                w_sel_state = req_state[128*i +: 128];
                w_sel_key   = req_key[128*i +: 128];
                w_sel_tag   = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // The job sitting in the issue register already owns a credit even though
    // it has not yet entered the shadow pipeline.
    assign w_credit_used = UW'(in_flight_q) + UW'(fifo_cnt_q) + UW'(issue_v_q);
    assign w_issue_ok    = (w_credit_used - UW'(w_pop)) < UW'(FIFO_DEPTH);
    assign w_hs          = w_grant_any & w_issue_ok & ~rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_hs && (w_grant_idx == SRC_W'(i));
        end
    end

    always_comb begin
        rr_d         = rr_q;
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        issue_v_d    = w_hs;
        issue_src_d  = issue_src_q;
        issue_tag_d  = issue_tag_q;
        if (w_hs) begin
            core_state_d = w_sel_state;
            core_key_d   = w_sel_key;
            issue_src_d  = w_grant_idx;
            issue_tag_d  = w_sel_tag;
            rr_d         = (w_grant_idx == SRC_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q         <= '0;
            core_state_q <= '0;
            core_key_q   <= '0;
            issue_v_q    <= 1'b0;
            issue_src_q  <= '0;
            issue_tag_q  <= '0;
        end else begin
            rr_q         <= rr_d;
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            issue_v_q    <= issue_v_d;
            issue_src_q  <= issue_src_d;
            issue_tag_q  <= issue_tag_d;
        end
    end

    // Stage 0 loads on the same edge the core samples its inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                sh_v_q[i]   <= 1'b0;
                sh_src_q[i] <= '0;
                sh_tag_q[i] <= '0;
            end
        end else begin
            sh_v_q[0]   <= issue_v_q;
            sh_src_q[0] <= issue_src_q;
            sh_tag_q[0] <= issue_tag_q;
            for (int i = 1; i < LATENCY; i++) begin
                sh_v_q[i]   <= sh_v_q[i-1];
                sh_src_q[i] <= sh_src_q[i-1];
                sh_tag_q[i] <= sh_tag_q[i-1];
            end
        end
    end

    assign w_push = sh_v_q[LATENCY-1];
    assign w_pop  = rsp_valid & rsp_ready;

    always_comb begin
        in_flight_d = in_flight_q + CW'(issue_v_q) - CW'(w_push);
        wr_ptr_d    = wr_ptr_q + AW'(w_push);
        rd_ptr_d    = rd_ptr_q + AW'(w_pop);
        fifo_cnt_d  = fifo_cnt_q + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_data_q[wr_ptr_q] <= core_out;
            fifo_src_q[wr_ptr_q]  <= sh_src_q[LATENCY-1];
            fifo_tag_q[wr_ptr_q]  <= sh_tag_q[LATENCY-1];
        end
    end

    assign core_state = core_state_q;
    assign core_key   = core_key_q;
    assign rsp_valid  = (fifo_cnt_q != '0);
    assign rsp_data   = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_src    = rsp_valid ? fifo_src_q[rd_ptr_q]  : '0;
    assign rsp_tag    = rsp_valid ? fifo_tag_q[rd_ptr_q]  : '0;
    assign busy       = (in_flight_q != '0) | issue_v_q | rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// tb_aes_job_scheduler : directed self-checking bench with a latency-matched
//                        stand-in AES core and a response scoreboard
// Revision             : 1.0
// ============================================================================
module tb_aes_job_scheduler;

    localparam int NREQ       = 3;
    localparam int LATENCY    = 21;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 32;
    localparam int SRC_W      = $clog2(NREQ);

    localparam logic [127:0] KAT_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MIX_C = 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*128-1:0]   req_state;
    logic [NREQ*128-1:0]   req_key;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [127:0]          core_state;
    logic [127:0]          core_key;
    logic [127:0]          core_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [127:0]          rsp_data;
    logic [SRC_W-1:0]      rsp_src;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  busy;

    aes_job_scheduler #(
        .NREQ       (NREQ),
        .LATENCY    (LATENCY),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_state  (req_state),
        .req_key    (req_key),
        .req_tag    (req_tag),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_src    (rsp_src),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in core: the known-answer vector returns true AES, anything else a keyed mix
    function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
        if (s == KAT_P && k == KAT_K) return KAT_C;
        return s ^ {k[63:0], k[127:64]} ^ MIX_C;
    endfunction

    logic [127:0] cpipe [LATENCY];
    always @(posedge clk) begin
        cpipe[0] <= core_fn(core_state, core_key);
        for (int i = 1; i < LATENCY; i++) cpipe[i] <= cpipe[i-1];
    end
    assign core_out = cpipe[LATENCY-1];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [127:0]     d;
        logic [SRC_W-1:0] s;
        logic [TAG_W-1:0] t;
    } rsp_t;

    rsp_t exp_q [$];
    int   grant_q [$];
    rsp_t mon_e;
    int   n_hs = 0;
    int   n_rsp = 0;
    int   hs_edge = 0;
    int   last_pop_edge = 0;

    // Monitor: sampled mid-cycle, records what the next edge will commit
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                last_pop_edge = cyc + 1;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {127'b0, rsp_valid}, 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_data", rsp_data, mon_e.d);
                    check("rsp_src", rsp_src, mon_e.s);
                    check("rsp_tag", rsp_tag, mon_e.t);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.d = core_fn(req_state[128*i +: 128], req_key[128*i +: 128]);
                    mon_e.s = SRC_W'(i);
                    mon_e.t = req_tag[TAG_W*i +: TAG_W];
                    exp_q.push_back(mon_e);
                    grant_q.push_back(i);
                    n_hs++;
                    hs_edge = cyc + 1;
                end
            end
            check("ready_onehot0", {127'b0, $onehot0(req_ready)}, 128'd1);
            if (dut.w_push && dut.fifo_cnt_q == FIFO_DEPTH) begin
                check("fifo_overflow", dut.fifo_cnt_q, FIFO_DEPTH - 1);
            end
        end
    end

    task automatic set_req(input int i, input logic [127:0] s, input logic [127:0] k,
                           input logic [TAG_W-1:0] t);
        req_state[128*i +: 128]     = s;
        req_key[128*i +: 128]       = k;
        req_tag[TAG_W*i +: TAG_W]   = t;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int max);
        int t = 0;
        @(negedge clk);
        while (!rsp_valid && t < max) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_idle(input string tag, input int max, output int idle_cyc);
        int t = 0;
        @(negedge clk);
        while (busy && t < max) begin
            @(negedge clk);
            t++;
        end
        idle_cyc = cyc;
        check(tag, {127'b0, busy}, 128'd0);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int h0, r0, g0, lat, idle_c;
    int gaps [5] = '{1, 2, 3, 2, 1};

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '1;
        req_state = '1;
        req_key   = '1;
        req_tag   = '1;
        step(2);

        // Reset state, with requests present
        check("rst_req_ready", req_ready, 0);
        check("rst_core_state", core_state, 0);
        check("rst_core_key", core_key, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_src", rsp_src, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_busy", busy, 0);
        req_valid = '0;
        rst       = 1'b0;
        step(1);

        // Single known-answer job
        set_req(0, KAT_P, KAT_K, 4'd5);
        rsp_ready = 1'b1;
        req_valid = 3'b001;
        #1;
        check("t1_ready", req_ready, 3'b001);
        step(1);
        req_valid = '0;
        check("t1_core_state", core_state, KAT_P);
        check("t1_core_key", core_key, KAT_K);
        wait_rsp(60);
        check("t1_rsp_seen", rsp_valid, 1);
        lat = cyc - hs_edge;
        check("t1_latency", lat, LATENCY + 1);
        check("t1_data", rsp_data, KAT_C);
        check("t1_src", rsp_src, 0);
        check("t1_tag", rsp_tag, 5);
        step(1);
        wait_idle("t1_idle", 40, idle_c);

        // All requesters valid: rotation starts at 1 after the grant to 0
        set_req(0, 128'h1111_0000, 128'hAAAA, 4'd1);
        set_req(1, 128'h2222_0000, 128'hBBBB, 4'd2);
        set_req(2, 128'h3333_0000, 128'hCCCC, 4'd3);
        g0 = grant_q.size();
        h0 = n_hs;
        req_valid = '1;
        step(12);
        req_valid = '0;
        check("t2_issues", n_hs - h0, 12);
        for (int k = 0; k < 12; k++) begin
            check("t2_grant", (g0 + k < grant_q.size()) ? grant_q[g0 + k] : -1, (1 + k) % NREQ);
        end
        wait_idle("t2_idle", 100, idle_c);

        // Credit limit with a stalled consumer
        rsp_ready = 1'b0;
        set_req(0, 128'h4444_5555, 128'h6666, 4'd7);
        h0 = n_hs;
        req_valid = 3'b001;
        step(60);
        check("t3_accepted", n_hs - h0, FIFO_DEPTH);
        check("t3_ready_low", req_ready, 0);
        check("t3_busy", busy, 1);
        rsp_ready = 1'b1;
        #1;
        check("t3_ready_on_pop", req_ready, 3'b001);
        step(1);
        rsp_ready = 1'b0;
        step(5);
        check("t3_one_more", n_hs - h0, FIFO_DEPTH + 1);
        check("t3_ready_low2", req_ready, 0);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("t3_idle", 200, idle_c);

        // Sparse issue: bubbles must not reach the FIFO
        rsp_ready = 1'b0;
        r0 = n_rsp;
        for (int j = 0; j < 5; j++) begin
            set_req(1, 128'h7000 + 128'(j), 128'h1234, 4'(8 + j));
            req_valid = 3'b010;
            step(1);
            req_valid = '0;
            step(gaps[j]);
        end
        step(LATENCY + 5);
        check("t4_fifo_cnt", dut.fifo_cnt_q, 5);
        check("t4_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        wait_idle("t4_idle", 60, idle_c);
        check("t4_rsp_count", n_rsp - r0, 5);

        // Reset while jobs are in flight
        set_req(2, 128'h9999_8888, 128'h7777, 4'd11);
        req_valid = 3'b100;
        step(8);
        req_valid = '0;
        step(10);
        check("t5_busy_pre", busy, 1);
        req_valid = 3'b100;
        rst = 1'b1;
        #1;
        check("t5_core_state", core_state, 0);
        check("t5_core_key", core_key, 0);
        check("t5_busy", busy, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_req_ready", req_ready, 0);
        step(2);
        rst = 1'b0;
        req_valid = '0;
        r0 = n_rsp;
        step(LATENCY + 10);
        check("t5_no_rsp", n_rsp - r0, 0);
        check("t5_idle_after", busy, 0);
        set_req(1, KAT_P, KAT_K, 4'd9);
        req_valid = 3'b010;
        #1;
        check("t5_ready_new", req_ready, 3'b010);
        step(1);
        req_valid = '0;
        wait_rsp(60);
        check("t5_rsp_seen", rsp_valid, 1);
        check("t5_data", rsp_data, KAT_C);
        check("t5_src", rsp_src, 1);
        check("t5_tag", rsp_tag, 9);
        step(1);
        wait_idle("t5_idle", 40, idle_c);

        // Issue, capture and pop all coinciding, then busy falls after last pop
        set_req(0, 128'hABCD_0001, 128'h0101, 4'd12);
        set_req(1, 128'hABCD_0002, 128'h0202, 4'd13);
        h0 = n_hs;
        r0 = n_rsp;
        req_valid = 3'b011;
        step(30);
        req_valid = '0;
        check("t6_issues", n_hs - h0, 30);
        wait_idle("t6_idle", 100, idle_c);
        check("t6_rsp_count", n_rsp - r0, 30);
        check("t6_busy_fall", idle_c, last_pop_edge);

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
